renamed_regfile: RTL
====================

Name: renamed_regfile

Overview:
- Parametrised successor to the scalar two-read register file, for the Tomasulo core.
- Holds architectural registers plus a per-register rename state (busy bit and ROB tag).
- Serves RD_PORTS combinational reads that return data, busy and tag together.
- Decode renames destinations into it, ROB commit retires values into it, and branch mispredict flush clears all rename state.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width; NREG <= 2**ADDR_W.
- TAG_W, 4, ROB tag width.
- RD_PORTS, 2, number of independent read ports.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global ready; when low, no state changes.
- rename_en_in  input  1  mark a destination register as renamed this cycle.
- rename_addr_in  input  ADDR_W  register being renamed.
- rename_tag_in  input  TAG_W  ROB tag of the new producer.
- commit_en_in  input  1  ROB commit writes a register this cycle.
- commit_addr_in  input  ADDR_W  register being committed.
- commit_data_in  input  XLEN  value being committed.
- commit_tag_in  input  TAG_W  ROB tag of the committing entry.
- flush_in  input  1  mispredict flush of all rename state.
- rd_addr_in  input  RD_PORTS*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data_out  output  RD_PORTS*XLEN  packed read data.
- rd_busy_out  output  RD_PORTS  per-port flag: value still pending from the ROB.
- rd_tag_out  output  RD_PORTS*TAG_W  per-port producer tag; valid only when busy.
- busy_cnt_out  output  ADDR_W+1  registered count of busy registers.

Behaviour:
- Reset (rst_n_in low, asynchronous, at any time including mid-operation):
  - all data, busy and tag state clears to 0.
  - busy_cnt_out = 0.
  - read outputs reflect the cleared state combinationally.
- Update gating: state updates only on a rising clk_in edge with rst_n_in high and rdy_in high. With rdy_in low, all inputs are ignored and the state holds.
- Commit (commit_en_in=1, commit_addr_in != 0):
  - data[addr] <= commit_data_in, unconditionally.
  - busy[addr] <= 0 only if busy[addr]=1 and tag[addr]==commit_tag_in.
  - On a tag mismatch, the register stays busy (a newer producer owns it).
- Rename (rename_en_in=1, rename_addr_in != 0): busy[addr] <= 1, tag[addr] <= rename_tag_in.
- Commit and rename to the same register in the same cycle: the rename wins for busy and tag; the data is still written.
- Flush:
  - flush_in=1: every busy bit <= 0 and any rename that cycle is dropped.
  - A commit in the same cycle still writes its data.
- Register 0: never written, never busy; always reads data 0, busy 0, tag 0.
- Reads are combinational with commit bypass. For each port i, when rd_addr=a:
  - a==0: outputs 0/0/0.
  - Bypass case: commit_en_in and rdy_in are high, commit_addr_in==a, and busy[a]=1 with tag[a]==commit_tag_in. Then data=commit_data_in, busy=0.
  - Otherwise: data=data[a], busy=busy[a], tag=tag[a].
  - A same-cycle rename never affects reads; it is visible from the next cycle.
- busy_cnt_out: registered popcount of the busy bits after the edge's update. Range 0..NREG-1.
- Out-of-range addresses (>= NREG): reads return 0/0/0; writes and renames are ignored.

Test Plan:
- Reset then read x5 on both ports -> data 0, busy 0, busy_cnt_out 0. Assert rst_n_in low mid-stream after writes -> all outputs 0 immediately.
- Rename x3 with tag 7; next cycle read x3 -> busy 1, tag 7, busy_cnt 1. Commit x3 tag 7 with data 0xDEADBEEF -> same-cycle read shows data 0xDEADBEEF, busy 0; next cycle busy_cnt 0.
- Rename x4 tag 2, then rename x4 tag 9, then commit x4 tag 2 with data 0x11 -> data 0x11, busy stays 1 with tag 9.
- Same cycle: commit x6 tag 1 (x6 busy with tag 1) and rename x6 tag 5 -> next cycle busy 1, tag 5, data is the committed value.
- Rename x1, x2 and x7, then flush_in together with commit x2 data 0x55 -> next cycle all busy 0, busy_cnt 0, x2 data 0x55.
- rdy_in low with commit and rename asserted -> no state change. Rename or commit to x0 -> x0 still reads 0, not busy.

Source files
------------

// File: rtl/renamed_regfile.sv
// Renamed register file: architectural data plus per-register busy/tag
// rename state, commit bypass on reads, flush of all rename state.
//
// Ports:
//   clk_in, rst_n_in  clock, async active-low reset
//   rdy_in            global ready; low freezes all state
//   rename_*          mark a destination busy with a new ROB tag
//   commit_*          ROB commit writes data, clears busy on tag match
//   flush_in          clear every busy bit, drop same-cycle rename
//   rd_addr_in        packed read addresses, RD_PORTS ports
//   rd_data_out, rd_busy_out, rd_tag_out  combinational read results
//   busy_cnt_out      registered count of busy registers
module renamed_regfile #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ADDR_W   = 5,
  parameter int TAG_W    = 4,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       rename_en_in,
  input  logic [ADDR_W-1:0]          rename_addr_in,
  input  logic [TAG_W-1:0]           rename_tag_in,
  input  logic                       commit_en_in,
  input  logic [ADDR_W-1:0]          commit_addr_in,
  input  logic [XLEN-1:0]            commit_data_in,
  input  logic [TAG_W-1:0]           commit_tag_in,
  input  logic                       flush_in,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr_in,
  output logic [RD_PORTS*XLEN-1:0]   rd_data_out,
  output logic [RD_PORTS-1:0]        rd_busy_out,
  output logic [RD_PORTS*TAG_W-1:0]  rd_tag_out,
  output logic [ADDR_W:0]            busy_cnt_out
);

  logic [XLEN-1:0]  data_q [NREG];
  logic [XLEN-1:0]  data_d [NREG];
  logic [TAG_W-1:0] tag_q  [NREG];
  logic [TAG_W-1:0] tag_d  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [ADDR_W:0]  cnt_d;

  // x0 and addresses beyond the file are never written or renamed.
  function automatic logic writable(
    input logic [ADDR_W-1:0] a
  );
    return (a != '0) && (32'(a) < 32'(NREG));
  endfunction

  logic commit_ok;
  logic rename_ok;
  logic commit_hit;

  assign commit_ok = commit_en_in
                   && writable(commit_addr_in);
  assign rename_ok = rename_en_in
                   && writable(rename_addr_in);
  assign commit_hit = commit_ok
                    && busy_q[commit_addr_in]
                    && (tag_q[commit_addr_in]
                        == commit_tag_in);

  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy_in) begin
      if (commit_ok) begin
        data_d[commit_addr_in] = commit_data_in;
      end
      if (commit_hit) begin
        busy_d[commit_addr_in] = 1'b0;
      end
      // Flush drops the rename; otherwise rename
      // overrides a same-register commit clear.
      if (flush_in) begin
        busy_d = '0;
      end else if (rename_ok) begin
        busy_d[rename_addr_in] = 1'b1;
        tag_d[rename_addr_in]  = rename_tag_in;
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d
            + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q       <= '{default: '0};
      tag_q        <= '{default: '0};
      busy_q       <= '0;
      busy_cnt_out <= '0;
    end else begin
      data_q       <= data_d;
      tag_q        <= tag_d;
      busy_q       <= busy_d;
      busy_cnt_out <= cnt_d;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [XLEN-1:0]   d;
    logic [TAG_W-1:0]  t;
    logic              b;
    logic              byp;

    assign a = rd_addr_in[p*ADDR_W +: ADDR_W];

    // Forward a retiring value that will clear busy
    // at this edge, so consumers need not wait.
    assign byp = commit_hit && rdy_in
               && (commit_addr_in == a);

    always_comb begin
      d = '0;
      b = 1'b0;
      t = '0;
      if (writable(a)) begin
        t = tag_q[a];
        if (byp) begin
          d = commit_data_in;
        end else begin
          d = data_q[a];
          b = busy_q[a];
        end
      end
    end

    assign rd_data_out[p*XLEN +: XLEN]   = d;
    assign rd_busy_out[p]                = b;
    assign rd_tag_out[p*TAG_W +: TAG_W]  = t;
  end

endmodule
